// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-driven ALU command interface:
// opcode constants, FSM state encoding and default bus widths.
package alu_uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OP_WIDTH   = 6;

    // Opcodes are full-byte values; the top two bits of a valid opcode byte are always zero.
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_A  = 3'd1,
        ST_WAIT_B  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WAIT_A) || (s == ST_WAIT_B);
    endfunction

endpackage

// File: rtl/intf_timeout_cnt.sv
// Inter-byte timeout counter: counts enabled cycles and flags the cycle in
// which the count reaches TIMEOUT_CLKS-1.
module intf_timeout_cnt #(
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    // The value held during the cycle whose increment lands on TIMEOUT_CLKS-1.
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CLKS - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/alu_uart_intf.sv
// Collects opcode, A and B bytes from a UART receiver, drives an external ALU
// and hands the registered result to the UART transmitter.
module alu_uart_intf
    import alu_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH     = DEFAULT_OP_WIDTH,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_err,
    output logic                  o_busy
);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [OP_WIDTH-1:0]   alu_op_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic                  err_q;
    logic                  busy_q;

    logic op_valid;
    logic in_wait;
    logic tmo_clear;
    logic tmo_expired;

    // Whole-byte match, so any byte with stray high bits is rejected.
    always_comb begin
        op_valid = 1'b0;
        case (i_rx_data)
            DATA_WIDTH'(OP_ADD), DATA_WIDTH'(OP_SUB), DATA_WIDTH'(OP_AND),
            DATA_WIDTH'(OP_OR),  DATA_WIDTH'(OP_XOR), DATA_WIDTH'(OP_NOR),
            DATA_WIDTH'(OP_SRA), DATA_WIDTH'(OP_SRL): op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    assign in_wait   = is_wait_state(state_q);
    assign tmo_clear = !in_wait || i_rx_done;

    intf_timeout_cnt #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .clear_i   (tmo_clear),
        .enable_i  (in_wait),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        if (op_valid) begin
                            alu_op_q <= i_rx_data[OP_WIDTH-1:0];
                            state_q  <= ST_WAIT_A;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // A byte arriving on the expiry cycle wins over the timeout.
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        alu_a_q <= i_rx_data;
                        state_q <= ST_WAIT_B;
                    end else if (tmo_expired) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        alu_b_q <= i_rx_data;
                        state_q <= ST_EXEC;
                    end else if (tmo_expired) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                // tx_start is raised here so that it is high exactly while in SEND.
                ST_EXEC: begin
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                    err_q      <= i_rx_done;
                end
                ST_SEND: begin
                    state_q <= ST_WAIT_TX;
                    err_q   <= i_rx_done;
                end
                ST_WAIT_TX: begin
                    err_q <= i_rx_done;
                    if (i_tx_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_intf.sv
// Self-checking bench for alu_uart_intf: directed scenarios plus randomized
// transactions checked against a behavioural ALU/protocol model.
module tb_alu_uart_intf;

    localparam int DW  = 8;
    localparam int OW  = 6;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic [DW-1:0] alu_result;
    logic          tx_done;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    alu_uart_intf #(
        .DATA_WIDTH   (DW),
        .OP_WIDTH     (OW),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_err        (err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU, used both as the external ALU and as the reference.
    function automatic logic [7:0] ref_alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'(sa >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_valid_op(input logic [7:0] b);
        for (int i = 0; i < 8; i++) if (valid_ops[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    assign alu_result = ref_alu(alu_op, alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Stimulus only: three bytes, then EXEC and SEND, leaving the DUT in WAIT_TX.
    task automatic start_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = 8'h00;
        #2;
        n_checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: a=%h b=%h op=%h tx=%h start=%b err=%b busy=%b, required all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, err, busy);
        end
        send_byte(8'h20);
        tick();
        n_checks++;
        if ({alu_op, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: op=%h busy=%b err=%b, required 0 while reset held", alu_op, busy, err);
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_transaction(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] exp;
        int         n_wait;
        exp = ref_alu(op[5:0], a, b);
        send_byte(op);
        n_checks++;
        if (alu_op !== op[5:0] || busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_op: op=%h busy=%b err=%b, required op=%h busy=1 err=0", tag, alu_op, busy, err, op[5:0]);
        end
        send_byte(a);
        n_checks++;
        if (alu_a !== a) begin
            n_fail++;
            $display("FAIL %s_a: got %h, required %h", tag, alu_a, a);
        end
        send_byte(b);
        n_checks++;
        if (alu_b !== b || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_b: b=%h start=%b, required b=%h start=0", tag, alu_b, tx_start, b);
        end
        tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== exp) begin
            n_fail++;
            $display("FAIL %s_start: start=%b tx=%h, required start=1 tx=%h (2 clocks after B)", tag, tx_start, tx_data, exp);
        end
        tick();
        n_checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pulse: start=%b busy=%b, required start=0 busy=1", tag, tx_start, busy);
        end
        n_wait = $urandom_range(0, 3);
        for (int i = 0; i < n_wait; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b1 || tx_start !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_wait_tx: busy=%b start=%b, required busy=1 start=0", tag, busy, tx_start);
            end
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0 || tx_data !== exp) begin
            n_fail++;
            $display("FAIL %s_done: busy=%b err=%b tx=%h, required busy=0 err=0 tx=%h", tag, busy, err, tx_data, exp);
        end
        $display("txn %s op=%h a=%h b=%h -> tx=%h (exp %h)", tag, op, a, b, tx_data, exp);
    endtask

    task automatic test_normal();
        test_transaction("normal", 8'h20, 8'h05, 8'h03);
        n_checks++;
        if (tx_data !== 8'h08) begin
            n_fail++;
            $display("FAIL normal_result: got %h, required 08", tx_data);
        end
    endtask

    task automatic test_invalid_opcode();
        logic [OW-1:0] op_before;
        logic [DW-1:0] tx_before;
        op_before = alu_op;
        tx_before = tx_data;
        send_byte(8'h3F);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_op !== op_before || tx_data !== tx_before) begin
            n_fail++;
            $display("FAIL invalid_3f: err=%b busy=%b op=%h tx=%h, required err=1 busy=0 op=%h tx=%h",
                     err, busy, alu_op, tx_data, op_before, tx_before);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_pulse_len: err=%b, required 0 one cycle later", err);
        end
        send_byte(8'h60);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_op !== op_before) begin
            n_fail++;
            $display("FAIL invalid_hibits: err=%b busy=%b op=%h, required err=1 busy=0 op=%h", err, busy, alu_op, op_before);
        end
        test_transaction("after_invalid", 8'h22, 8'h09, 8'h04);
        n_checks++;
        if (tx_data !== 8'h05) begin
            n_fail++;
            $display("FAIL after_invalid_result: got %h, required 05", tx_data);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] a_before;
        send_byte(8'h24);
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (err !== (k == TMO - 1) || busy !== (k < TMO - 1)) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: err=%b busy=%b, required err=%b busy=%b",
                         k, err, busy, (k == TMO - 1), (k < TMO - 1));
            end
        end
        a_before = alu_a;
        send_byte(8'h05);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_op !== 6'h24 || alu_a !== a_before) begin
            n_fail++;
            $display("FAIL timeout_next_is_op: err=%b busy=%b op=%h a=%h, required err=1 busy=0 op=24 a=%h",
                     err, busy, alu_op, alu_a, a_before);
        end
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_timeout_boundary();
        send_byte(8'h25);
        for (int k = 1; k < TMO - 1; k++) tick();
        send_byte(8'hA5);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || alu_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL timeout_edge_a: err=%b busy=%b a=%h, required err=0 busy=1 a=a5", err, busy, alu_a);
        end
        for (int k = 1; k < TMO - 1; k++) tick();
        send_byte(8'h0F);
        tick();
        n_checks++;
        if (err !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'hAF) begin
            n_fail++;
            $display("FAIL timeout_edge_b: err=%b start=%b tx=%h, required err=0 start=1 tx=af", err, tx_start, tx_data);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        $display("test_timeout_boundary done");
    endtask

    task automatic test_collisions();
        logic [7:0] exp;
        exp = ref_alu(6'h26, 8'h3C, 8'h0F);
        send_byte(8'h26);
        send_byte(8'h3C);
        send_byte(8'h0F);
        send_byte(8'h11);
        n_checks++;
        if (err !== 1'b1 || tx_start !== 1'b1 || tx_data !== exp || alu_a !== 8'h3C) begin
            n_fail++;
            $display("FAIL coll_exec: err=%b start=%b tx=%h a=%h, required err=1 start=1 tx=%h a=3c",
                     err, tx_start, tx_data, alu_a, exp);
        end
        tick();
        send_byte(8'h99);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1 || tx_data !== exp || alu_b !== 8'h0F) begin
            n_fail++;
            $display("FAIL coll_wait_tx: err=%b busy=%b tx=%h b=%h, required err=1 busy=1 tx=%h b=0f",
                     err, busy, tx_data, alu_b, exp);
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_wait_tx_after: err=%b busy=%b, required err=0 busy=1", err, busy);
        end
        rx_data = 8'h20;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_op !== 6'h26) begin
            n_fail++;
            $display("FAIL coll_rx_tx: err=%b busy=%b op=%h, required err=1 busy=0 op=26", err, busy, alu_op);
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_rx_tx_after: err=%b busy=%b, required err=0 busy=0", err, busy);
        end
        $display("test_collisions done");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h20);
        send_byte(8'h07);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: a=%h b=%h op=%h tx=%h start=%b err=%b busy=%b, required all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, err, busy);
        end
        tick();
        rst_n = 1'b1;
        test_transaction("after_reset", 8'h02, 8'h10, 8'h01);
        n_checks++;
        if (tx_data !== 8'h08) begin
            n_fail++;
            $display("FAIL after_reset_result: got %h, required 08", tx_data);
        end
    endtask

    task automatic test_random();
        logic [7:0]    bad;
        logic [OW-1:0] op_before;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                bad = 8'($urandom);
                op_before = alu_op;
                send_byte(bad);
                n_checks++;
                if (err !== !is_valid_op(bad) || (!is_valid_op(bad) && alu_op !== op_before)) begin
                    n_fail++;
                    $display("FAIL rand_opcode_%0d: byte=%h err=%b op=%h", t, bad, err, alu_op);
                end
                if (is_valid_op(bad)) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                tick();
            end
            test_transaction($sformatf("rand%0d", t), valid_ops[$urandom_range(0, 7)], 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_invalid_opcode();
        test_timeout();
        test_timeout_boundary();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
